qtree_stream_loader: RTL
========================

// Module: qtree_stream_loader
// PURPOSE
// Parametrised host-side loader/launcher for QTree kernels. It deserialises NUM_TREES post-order AXI-stream
// token trees into DUT heap nodes through a write/pointer-return handshake, tracking child pointers on a stack.
// It then launches the kernel (go + one root pointer per tree) and captures the kernel's result pointer.
// Generalises the fixed 2-tree/4-ary loader with configurable arity, tree count and depth, plus error detection.
// PARAMETERS
//   NUM_TREES    2     number of input trees (root pointers) per launch, >=1
//   ARITY        4     children per node token
//   PTR_W        16    heap pointer width
//   VAL_W        64    leaf payload width
//   STACK_DEPTH  256   pointer stack entries, power of 2
//   (localparam) SP_W = $clog2(STACK_DEPTH)+1; WORD_W = 2 + max(VAL_W, ARITY*PTR_W)
// PORTS
//   clk           in   1                  clock
//   aresetn       in   1                  async active-low reset
//   s_tdata       in   2+VAL_W            token {payload, tag[1:0]}
//   s_tlast       in   1                  last token of current tree
//   s_tvalid      in   1                  token valid
//   s_tready      out  1                  token accepted when s_tvalid&s_tready
//   wr_valid      out  1                  heap write request
//   wr_data       out  WORD_W             heap word {fields, tag}
//   wr_ready      in   1                  heap accepts write
//   ptr_valid     in   1                  heap returns allocated pointer
//   ptr_data      in   PTR_W              allocated pointer
//   ptr_ready     out  1                  pointer accepted
//   go_valid      out  1                  kernel start token
//   go_ready      in   1                  kernel accepts go
//   root_valid    out  NUM_TREES          per-tree root pointer valid
//   root_ptr      out  NUM_TREES*PTR_W    root pointers, tree i at [i*PTR_W +: PTR_W]
//   root_ready    in   NUM_TREES          per-tree root accept
//   res_valid     in   1                  kernel result pointer valid
//   res_ptr       in   PTR_W              kernel result pointer
//   res_ready     out  1                  result accepted
//   result_valid  out  1                  captured result available to host
//   result_data   out  PTR_W              captured result pointer
//   result_ready  in   1                  host consumes result
//   done          out  1                  result consumed; sticky until reset
//   err           out  1                  sticky error
//   err_code      out  2                  0 none, 1 stack underflow, 2 stack overflow, 3 bad tree end
// BEHAVIOUR
// - Clock clk; reset aresetn asynchronous, active-low. On reset all outputs are 0: s_tready, wr_valid, ptr_ready,
//   go_valid, root_valid, res_ready, result_valid, done, err, err_code, root_ptr, result_data. State=LOAD, sp=0, tree_idx=0.
// - FSM: LOAD -> WRITE -> WAIT_PTR -> (LOAD | LAUNCH) ; LAUNCH -> RUN -> OUTPUT -> DONE ; any -> ERROR.
// - LOAD: s_tready=1. On accept, latch token and tlast.
//   Tags 0/1/3 are leaves: wr_data={payload,tag}, zero-padded.
//   Tag 2 is a node: sp<ARITY -> ERROR(1). Otherwise child k = stack[sp-ARITY+k], k=0 earliest pushed, packed
//   ascending above the tag.
// - WRITE: wr_valid held with stable wr_data until wr_ready. WAIT_PTR: ptr_ready=1. On ptr_valid, a node pops ARITY
//   then pushes ptr_data; a leaf pushes. Push with effective sp==STACK_DEPTH -> ERROR(2).
// - At tlast after push: sp!=1 -> ERROR(3). Otherwise root[tree_idx]=ptr_data, sp=0, tree_idx++.
//   tree_idx==NUM_TREES -> LAUNCH, else LOAD.
// - Latency per token: >=3 cycles (accept, write, ptr). Back-to-back tokens never overlap.
// - LAUNCH: go_valid and all root_valid asserted the cycle after entry. Each channel is independent and drops its
//   valid the cycle after its own ready (no repeat). Leave LAUNCH when all NUM_TREES+1 channels have completed.
//   Same-cycle readies are allowed.
// - RUN: res_ready=1. On res_valid capture res_ptr -> result_data, result_valid=1 (OUTPUT).
//   Hold until result_ready, then result_valid=0 and done=1 (DONE, terminal).
// - ERROR: all valids/readies 0; err=1, err_code held; terminal until reset. First error wins.
// - Reset mid-operation abandons all state immediately; the heap is not rolled back.
// STRUCTURE
// - Package qtree_loader_pkg: tag_e {Q_NONE=0, Q_VAL=1, Q_NODE=2, Q_ERR=3}, state_e, err_e, pack_node() function.
// - Sub-module qtree_ptr_stack: STACK_DEPTH x PTR_W regs, push/pop-N in one cycle, combinational read of top ARITY
//   entries, sp output.
// - Top holds the FSM, launch-channel done bits, and root/result registers.
// TESTING
// - Reset: aresetn low mid-WRITE -> all outputs 0 immediately (async). Restart loads cleanly.
// - Two single-leaf trees (tag1, payload 5, tlast). Heap returns ptrs 0x10, 0x11
//   -> root_ptr={0x11,0x10}, go and both roots issued once.
// - Tree of 4 leaves + node, heap ptrs 1..5 -> node wr_data children {4,3,2,1} high->low, root=5.
// - Node token with only 3 stack entries -> err=1, err_code=1, s_tready stays 0.
// - LAUNCH with go_ready delayed 5 cycles, roots ready at once -> roots drop after 1 cycle, go after 6, then RUN.
// - res_valid ptr 0x2A with result_ready low 3 cycles -> result_data=0x2A held. done=1 the cycle after result_ready.

Source files
------------

// File: rtl/qtree_loader_pkg.sv
// Shared types for the QTree stream loader: token tags, FSM states, error codes
// and the heap-word packing helper.
package qtree_loader_pkg;

  typedef enum logic [1:0] {
    Q_NONE = 2'd0,
    Q_VAL  = 2'd1,
    Q_NODE = 2'd2,
    Q_ERR  = 2'd3
  } tag_e;

  typedef enum logic [2:0] {
    StLoad,
    StWrite,
    StWaitPtr,
    StLaunch,
    StRun,
    StOutput,
    StDone,
    StError
  } state_e;

  typedef enum logic [1:0] {
    ErrNone      = 2'd0,
    ErrUnderflow = 2'd1,
    ErrOverflow  = 2'd2,
    ErrBadEnd    = 2'd3
  } err_e;

  // Widest field block supported; callers truncate the result to their word width.
  localparam int unsigned PackMaxW = 1024;

  function automatic logic [PackMaxW+1:0] pack_node(input logic [PackMaxW-1:0] fields,
                                                    input tag_e tag);
    return {fields, tag};
  endfunction

endpackage

// File: rtl/qtree_ptr_stack.sv
// Pointer stack with single-cycle pop-ARITY-then-push, clear, and a combinational
// view of the top ARITY entries (entry 0 = earliest pushed).
module qtree_ptr_stack #(
  parameter int unsigned ARITY       = 4,
  parameter int unsigned PTR_W       = 16,
  parameter int unsigned STACK_DEPTH = 256,
  localparam int unsigned SP_W       = $clog2(STACK_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  input  logic [PTR_W-1:0]       push_data_i,
  output logic [ARITY*PTR_W-1:0] top_o,
  output logic [SP_W-1:0]        sp_o
);

  localparam int unsigned IdxW = $clog2(STACK_DEPTH);

  logic [SP_W-1:0]  sp_q, sp_d, base;
  logic [PTR_W-1:0] mem_q [STACK_DEPTH];

  // A pop followed by a push in the same cycle writes over the oldest popped slot.
  assign base = pop_i ? sp_q - SP_W'(ARITY) : sp_q;

  always_comb begin
    sp_d = sp_q;
    if (clear_i) begin
      sp_d = '0;
    end else if (push_i) begin
      sp_d = base + SP_W'(1);
    end else if (pop_i) begin
      sp_d = base;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) begin
      mem_q[IdxW'(base)] <= push_data_i;
    end
  end

  for (genvar k = 0; k < ARITY; k++) begin : g_top
    logic [IdxW-1:0] idx;
    assign idx = IdxW'(sp_q - SP_W'(ARITY) + SP_W'(k));
    assign top_o[k*PTR_W +: PTR_W] = mem_q[idx];
  end

  assign sp_o = sp_q;

endmodule

// File: rtl/qtree_stream_loader.sv
// Deserialises post-order token trees into heap nodes, then launches the kernel with
// one root pointer per tree and captures its result pointer.
module qtree_stream_loader
  import qtree_loader_pkg::*;
#(
  parameter int unsigned NUM_TREES   = 2,
  parameter int unsigned ARITY       = 4,
  parameter int unsigned PTR_W       = 16,
  parameter int unsigned VAL_W       = 64,
  parameter int unsigned STACK_DEPTH = 256,
  localparam int unsigned SP_W       = $clog2(STACK_DEPTH) + 1,
  localparam int unsigned WORD_W     = 2 + ((VAL_W > ARITY*PTR_W) ? VAL_W : ARITY*PTR_W)
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic [VAL_W+1:0]           s_tdata,
  input  logic                       s_tlast,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  output logic                       wr_valid,
  output logic [WORD_W-1:0]          wr_data,
  input  logic                       wr_ready,
  input  logic                       ptr_valid,
  input  logic [PTR_W-1:0]           ptr_data,
  output logic                       ptr_ready,
  output logic                       go_valid,
  input  logic                       go_ready,
  output logic [NUM_TREES-1:0]       root_valid,
  output logic [NUM_TREES*PTR_W-1:0] root_ptr,
  input  logic [NUM_TREES-1:0]       root_ready,
  input  logic                       res_valid,
  input  logic [PTR_W-1:0]           res_ptr,
  output logic                       res_ready,
  output logic                       result_valid,
  output logic [PTR_W-1:0]           result_data,
  input  logic                       result_ready,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code
);

  localparam int unsigned TiW = $clog2(NUM_TREES + 1);

  state_e                     state_q, state_d;
  tag_e                       tag_q, tag_d;
  logic                       tlast_q, tlast_d;
  logic [WORD_W-1:0]          wr_data_q, wr_data_d;
  err_e                       err_code_q, err_code_d;
  logic [NUM_TREES*PTR_W-1:0] root_q, root_d;
  logic [TiW-1:0]             tree_idx_q, tree_idx_d;
  logic [PTR_W-1:0]           result_q, result_d;
  logic [NUM_TREES:0]         launch_done_q, launch_done_d;
  logic                       go_valid_q, go_valid_d;
  logic [NUM_TREES-1:0]       root_valid_q, root_valid_d;
  logic                       s_tready_q, wr_valid_q, ptr_ready_q, res_ready_q;
  logic                       result_valid_q, done_q, err_q;

  logic                       stk_push, stk_pop, stk_clear;
  logic [ARITY*PTR_W-1:0]     stk_top;
  logic [SP_W-1:0]            stk_sp, sp_new;
  logic [PackMaxW-1:0]        fields;

  qtree_ptr_stack #(
    .ARITY      (ARITY),
    .PTR_W      (PTR_W),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk        (clk),
    .aresetn    (aresetn),
    .push_i     (stk_push),
    .pop_i      (stk_pop),
    .clear_i    (stk_clear),
    .push_data_i(ptr_data),
    .top_o      (stk_top),
    .sp_o       (stk_sp)
  );

  always_comb begin
    state_d       = state_q;
    tag_d         = tag_q;
    tlast_d       = tlast_q;
    wr_data_d     = wr_data_q;
    err_code_d    = err_code_q;
    root_d        = root_q;
    tree_idx_d    = tree_idx_q;
    result_d      = result_q;
    launch_done_d = launch_done_q;
    go_valid_d    = go_valid_q;
    root_valid_d  = root_valid_q;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    stk_clear     = 1'b0;
    sp_new        = '0;
    fields        = '0;

    unique case (state_q)
      StLoad: begin
        if (s_tvalid && s_tready_q) begin
          tag_d   = tag_e'(s_tdata[1:0]);
          tlast_d = s_tlast;
          state_d = StWrite;
          if (tag_d == Q_NODE) begin
            fields[ARITY*PTR_W-1:0] = stk_top;
            if (stk_sp < SP_W'(ARITY)) begin
              state_d    = StError;
              err_code_d = ErrUnderflow;
            end
          end else begin
            fields[VAL_W-1:0] = s_tdata[VAL_W+1:2];
          end
          wr_data_d = WORD_W'(pack_node(fields, tag_d));
        end
      end

      StWrite: begin
        if (wr_ready) begin
          state_d = StWaitPtr;
        end
      end

      StWaitPtr: begin
        if (ptr_valid) begin
          sp_new = (tag_q == Q_NODE) ? stk_sp - SP_W'(ARITY) + SP_W'(1) : stk_sp + SP_W'(1);
          if (tag_q != Q_NODE && stk_sp == SP_W'(STACK_DEPTH)) begin
            state_d    = StError;
            err_code_d = ErrOverflow;
          end else if (tlast_q && sp_new != SP_W'(1)) begin
            state_d    = StError;
            err_code_d = ErrBadEnd;
          end else if (tlast_q) begin
            // The tree's only remaining entry is its root, so the stack is simply reset.
            for (int i = 0; i < NUM_TREES; i++) begin
              if (TiW'(i) == tree_idx_q) begin
                root_d[i*PTR_W +: PTR_W] = ptr_data;
              end
            end
            stk_clear  = 1'b1;
            tree_idx_d = tree_idx_q + TiW'(1);
            if (tree_idx_d == TiW'(NUM_TREES)) begin
              state_d      = StLaunch;
              go_valid_d   = 1'b1;
              root_valid_d = '1;
            end else begin
              state_d = StLoad;
            end
          end else begin
            stk_push = 1'b1;
            stk_pop  = (tag_q == Q_NODE);
            state_d  = StLoad;
          end
        end
      end

      StLaunch: begin
        for (int i = 0; i < NUM_TREES; i++) begin
          if (root_valid_q[i] && root_ready[i]) begin
            root_valid_d[i]  = 1'b0;
            launch_done_d[i] = 1'b1;
          end
        end
        if (go_valid_q && go_ready) begin
          go_valid_d               = 1'b0;
          launch_done_d[NUM_TREES] = 1'b1;
        end
        if (&launch_done_d) begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (res_valid && res_ready_q) begin
          result_d = res_ptr;
          state_d  = StOutput;
        end
      end

      StOutput: begin
        if (result_ready && result_valid_q) begin
          state_d = StDone;
        end
      end

      StDone, StError: begin
        state_d = state_q;
      end

      default: begin
        state_d = StError;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= StLoad;
      tag_q          <= Q_NONE;
      tlast_q        <= 1'b0;
      wr_data_q      <= '0;
      err_code_q     <= ErrNone;
      root_q         <= '0;
      tree_idx_q     <= '0;
      result_q       <= '0;
      launch_done_q  <= '0;
      go_valid_q     <= 1'b0;
      root_valid_q   <= '0;
      s_tready_q     <= 1'b0;
      wr_valid_q     <= 1'b0;
      ptr_ready_q    <= 1'b0;
      res_ready_q    <= 1'b0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      tag_q          <= tag_d;
      tlast_q        <= tlast_d;
      wr_data_q      <= wr_data_d;
      err_code_q     <= err_code_d;
      root_q         <= root_d;
      tree_idx_q     <= tree_idx_d;
      result_q       <= result_d;
      launch_done_q  <= launch_done_d;
      go_valid_q     <= go_valid_d;
      root_valid_q   <= root_valid_d;
      s_tready_q     <= (state_d == StLoad);
      wr_valid_q     <= (state_d == StWrite);
      ptr_ready_q    <= (state_d == StWaitPtr);
      res_ready_q    <= (state_d == StRun);
      result_valid_q <= (state_d == StOutput);
      done_q         <= (state_d == StDone);
      err_q          <= (state_d == StError);
    end
  end

  assign s_tready     = s_tready_q;
  assign wr_valid     = wr_valid_q;
  assign wr_data      = wr_data_q;
  assign ptr_ready    = ptr_ready_q;
  assign go_valid     = go_valid_q;
  assign root_valid   = root_valid_q;
  assign root_ptr     = root_q;
  assign res_ready    = res_ready_q;
  assign result_valid = result_valid_q;
  assign result_data  = result_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = err_code_q;

endmodule
